// File: rtl/stream_mux_pkg.sv
// ============================================================================
//  Module      : stream_mux_pkg
//  Description : Shared types and constants for the packet-aware stream
//                selector (FSM state encoding, arbitration mode values).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux_pkg;

    // IDLE arbitrates every cycle; LOCKED pins the output to one channel
    // until that channel's last beat has been accepted.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic MODE_PRIO = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage : stream_mux_pkg

`default_nettype wire

// File: rtl/stream_mux_arb.sv
// ============================================================================
//  Module      : stream_mux_arb
//  Description : Combinational N-way arbiter. Fixed priority (lowest index
//                wins) or round-robin starting one past rr_ptr_i, wrapping.
//                Produces a one-hot grant, its encoded index and a flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  rr_ptr_i,
    input  logic              mode_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [SEL_W-1:0]  grant_idx_o,
    output logic              grant_vld_o
);

    logic [SEL_W-1:0] cand;

    // Search for the first requester in the order dictated by the mode.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = '0;
        if (mode_i == MODE_RR) begin
            // Candidates rr_ptr+1 .. rr_ptr+NUM_CH, so the previous owner
            // is examined last.
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = SEL_W'((int'(rr_ptr_i) + k) % NUM_CH);
                if (!grant_vld_o && req_i[cand]) begin
                    grant_vld_o = 1'b1;
                    grant_idx_o = cand;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_vld_o && req_i[i]) begin
                    grant_vld_o = 1'b1;
                    grant_idx_o = SEL_W'(i);
                end
            end
        end
        grant_o[grant_idx_o] = grant_vld_o;
    end

endmodule : stream_mux_arb

`default_nettype wire

// File: rtl/stream_select_mux.sv
// ============================================================================
//  Module      : stream_select_mux
//  Description : N-channel packet-aware valid/ready selector. A granted
//                channel owns the output until its last beat. Registered
//                output stage, one-cycle latency, full throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_select_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_rr,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch
);

    import stream_mux_pkg::*;

    localparam logic [SEL_W-1:0] RR_PTR_RST = SEL_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SEL_W-1:0]    out_ch_q, out_ch_d;

    logic [NUM_CH-1:0]   grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                load_en;
    logic [SEL_W-1:0]    xfer_ch;
    logic                xfer;
    logic [DATA_W-1:0]   ch_data [NUM_CH];

    // Unpack the flat data bus so the selected beat can be indexed directly.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
    end

    // The arbiter result is only consulted in IDLE, so a mode change while
    // locked naturally takes effect at the next arbitration.
    stream_mux_arb #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req_i       (in_valid),
        .rr_ptr_i    (rr_ptr_q),
        .mode_i      (mode_rr),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    assign load_en = !out_valid_q || out_ready;

    // Ready steering: arbiter grant in IDLE, locked channel otherwise.
    // rst_n gates ready so nothing is accepted while reset is held.
    always_comb begin
        in_ready = '0;
        xfer_ch  = lock_ch_q;
        if (state_q == ST_IDLE) begin
            xfer_ch = grant_idx;
            if (rst_n && grant_vld && load_en) begin
                in_ready = grant;
            end
        end else if (rst_n) begin
            in_ready[lock_ch_q] = load_en;
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Packet FSM, lock channel and round-robin pointer next-state.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            if (in_last[xfer_ch]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = xfer_ch;
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = xfer_ch;
            end
        end
    end

    // Output register next-state: load on transfer, drain when consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[xfer_ch];
            out_last_d  = in_last[xfer_ch];
            out_ch_d    = xfer_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= RR_PTR_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule : stream_select_mux

`default_nettype wire

// File: tb/tb_stream_select_mux.sv
// ============================================================================
//  Module      : tb_stream_select_mux
//  Description : Randomized self-checking bench for stream_select_mux with a
//                packet-level reference model and a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_select_mux;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int NUM_CYC = 3000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode_rr;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_ch;

    stream_select_mux #(.NUM_CH(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_rr   (mode_rr),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [SW-1:0] c;
    } beat_t;

    beat_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    bit            done   = 1'b0;

    // Producer state: the beat each channel currently offers.
    logic [DW-1:0] cur_data [N];
    logic          cur_last [N];

    // Reference model: packet owner (-1 = arbitrating), RR pointer,
    // and whether the output register holds an unconsumed beat.
    int            owner;
    int            ptr;
    bit            held;
    logic [N-1:0]  exp_ready;
    bit            rst_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_beat(input int c);
        cur_data[c] = DW'($urandom);
        cur_last[c] = ($urandom_range(0, 2) == 0);
    endtask

    task automatic drive_data();
        for (int c = 0; c < N; c++) begin
            in_data[c*DW +: DW] = cur_data[c];
            in_last[c]          = cur_last[c];
        end
    endtask

    // Which channel the spec says should see ready this cycle.
    task automatic model_ready();
        int g;
        bit load;
        exp_ready = '0;
        load = !held || out_ready;
        g = -1;
        if (owner >= 0) begin
            g = owner;
        end else if (!mode_rr) begin
            for (int i = 0; i < N; i++)
                if (g < 0 && in_valid[i]) g = i;
        end else begin
            for (int k = 1; k <= N; k++)
                if (g < 0 && in_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (g >= 0 && load) exp_ready[g] = 1'b1;
    endtask

    // Monitor: every consumed output beat must match the scoreboard head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got beat ch=%0d data=%0h expected none", out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_last", 64'(out_last), 64'(e.l));
                    check("out_ch",   64'(out_ch),   64'(e.c));
                end
            end
        end
    end

    // Stimulus and model update.
    initial begin
        int xc;
        for (int c = 0; c < N; c++) new_beat(c);
        rst_n     = 1'b0;
        mode_rr   = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        drive_data();
        owner = -1; ptr = N - 1; held = 1'b0;

        // Reset state: outputs cleared and nothing accepted while in reset.
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_last",  64'(out_last),  64'(0));
        check("rst_out_ch",    64'(out_ch),    64'(0));

        @(posedge clk); #1;
        rst_n   = 1'b1;
        rst_cyc = 1'b0;
        model_ready();

        for (int cyc = 0; cyc < NUM_CYC; cyc++) begin
            @(negedge clk);
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            if (rst_cyc) begin
                check("mid_rst_out_valid", 64'(out_valid), 64'(0));
                check("mid_rst_out_data",  64'(out_data),  64'(0));
                check("mid_rst_out_ch",    64'(out_ch),    64'(0));
            end
            xc = -1;
            for (int c = 0; c < N; c++)
                if (in_valid[c] && exp_ready[c]) xc = c;

            @(posedge clk);
            if (xc >= 0) begin
                sb.push_back('{d: cur_data[xc], l: cur_last[xc], c: SW'(xc)});
                if (cur_last[xc]) begin
                    owner = -1;
                    ptr   = xc;
                end else begin
                    owner = xc;
                end
                held = 1'b1;
                new_beat(xc);
            end else if (out_ready && !rst_cyc) begin
                held = 1'b0;
            end

            #1;
            if (cyc >= NUM_CYC - 6) begin
                rst_cyc   = 1'b0;
                rst_n     = 1'b1;
                in_valid  = '0;
                out_ready = 1'b1;
            end else begin
                rst_cyc = ($urandom_range(0, 199) == 0);
                if (cyc % 37 == 0) mode_rr = 1'($urandom_range(0, 1));
                for (int c = 0; c < N; c++)
                    in_valid[c] = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 8);
            end
            drive_data();
            if (rst_cyc) begin
                rst_n = 1'b0;
                owner = -1;
                ptr   = N - 1;
                held  = 1'b0;
                sb.delete();
                exp_ready = '0;
            end else begin
                rst_n = 1'b1;
                model_ready();
            end
        end

        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        done = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stream_select_mux

`default_nettype wire

// File: doc/stream_select_mux.md
# stream_select_mux

Parametrised N-channel, packet-aware selector with valid/ready handshakes, a runtime choice of fixed-priority or round-robin arbitration, and a registered output stage. It generalises the four-way priority data select to streaming sources: a channel, once granted, holds the output until its packet ends. It sits between multiple upstream producers and a single downstream consumer.

## Interface
- `NUM_CH`, default 4: number of input channels; must be ≥ 1.
- `DATA_W`, default 8: data width per channel.
- `SEL_W`, default `$clog2(NUM_CH)` (minimum 1): width of the channel index.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_rr`  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- `in_valid`  in  NUM_CH  per-channel beat valid.
- `in_last`  in  NUM_CH  per-channel end-of-packet flag.
- `in_data`  in  NUM_CH×DATA_W  per-channel data, packed, channel 0 in LSBs.
- `in_ready`  out  NUM_CH  per-channel accept; at most one bit high.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_W  registered data.
- `out_last`  out  1  registered end-of-packet.
- `out_ch`  out  SEL_W  source channel of the current beat.

## Operation
- `load_en = !out_valid || out_ready`.
- A beat transfers on channel i when `in_valid[i] && in_ready[i]`. It is then loaded into the output register together with its last flag and its channel index.
- States are `ST_IDLE` and `ST_LOCKED`.
- **ST_IDLE arbitration** (combinational, same cycle):
  - Priority mode: grant the lowest-index valid channel.
  - RR mode: grant the first valid channel after `rr_ptr`, wrapping modulo NUM_CH.
  - `in_ready[g] = load_en` for the granted channel; all other bits are 0.
  - No valid channel gives no grant and all `in_ready` at 0.
- **ST_IDLE transitions**:
  - Accepted beat with `in_last = 0`: go to ST_LOCKED and record `lock_ch = g`.
  - Accepted beat with `in_last = 1`: single-beat packet; stay in ST_IDLE.
- **ST_LOCKED**:
  - `in_ready[lock_ch] = load_en`, independent of `in_valid`; all other bits are 0.
  - An accepted beat with `in_last = 1` returns the block to ST_IDLE.
  - If the locked channel drops `in_valid`, the output bubbles. No other channel is granted.
- `rr_ptr` updates to the packet's channel only when its last beat is accepted, in either mode.
- `mode_rr` is sampled only during ST_IDLE arbitration. A change while locked takes effect at the next arbitration.
- Output register:
  - On transfer it loads data, last and channel, and sets `out_valid`.
  - Otherwise, `out_ready` with no transfer clears `out_valid`.
  - While `out_valid && !out_ready`, all outputs hold stable.
- `NUM_CH = 1`: the arbiter degenerates to channel 0. `out_ch` is always 0.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_ch` = 0.
  - State = ST_IDLE, `lock_ch` = 0, `rr_ptr` = NUM_CH−1, so the first RR search starts at channel 0.
- While `rst_n` is low, `in_ready` is all 0.
- Latency is 1 cycle: a beat accepted at edge k appears on `out_*` after edge k.
- Throughput is 1 beat/cycle with `out_ready` held high. This includes back-to-back packets from different channels, with no idle cycle between a last beat and the next grant.
- Reset asserted mid-packet:
  - Immediately returns to ST_IDLE and clears the output register.
  - The partial packet is discarded; there is no recovery.
- Simultaneous drain and load (`out_valid && out_ready` plus a transfer) replaces the register contents in the same edge.

## Structure
- Package `stream_mux_pkg`:
  - `state_t` enum {ST_IDLE, ST_LOCKED}.
  - Mode constants `MODE_PRIO = 1'b0`, `MODE_RR = 1'b1`.
- One sub-module, `stream_mux_arb`, handles the combinational grant.
  - Inputs: request vector, `rr_ptr`, mode.
  - Outputs: one-hot grant plus encoded index.
  - Parametrised on NUM_CH.
- The top level holds the FSM, `lock_ch`, `rr_ptr` and the output register.

## Test plan
- **Priority mode, all 4 channels valid, single-beat packets** (data 0x10/0x11/0x12/0x13), `out_ready = 1`:
  - Outputs 0x10 four times while channel 0 stays valid.
  - After dropping ch0 valid, outputs 0x11.
- **RR mode, all valid, single-beat packets, out_ready high**:
  - `out_ch` sequence is 0,1,2,3,0 on consecutive cycles with no bubbles.
- **Packet lock**: ch2 sends 3 beats (last on the third) while ch0 is also valid in priority mode.
  - Output is ch2 ×3, then ch0.
  - `in_ready[0]` stays 0 throughout the ch2 packet.
- **Backpressure**: hold `out_ready = 0` for 5 cycles with `out_valid = 1`, data 0xA5.
  - `out_data` stays 0xA5 and all `in_ready` are 0.
  - On release, the next beat appears 1 cycle later.
- **Reset mid-packet**: assert `rst_n` low after beat 2 of a 4-beat ch1 packet.
  - All outputs are 0 and the state is ST_IDLE.
  - The next grant in RR mode starts at ch0.
- **Mode switch while locked**: set `mode_rr = 1` during a ch3 packet.
  - The ch3 packet completes.
  - The next grant is the first valid channel after ch3, wrapping to ch0.
